// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus
// One bus transaction per memory instruction; stalls the front of the pipe until data_ok arrives.
module mem_access_unit #(
    parameter logic [5:0] EXC_ADEL = 6'h04,
    parameter logic [5:0] EXC_ADES = 6'h05
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  stall,
    input  logic [31:0] input_inst,
    input  logic [31:0] input_write_data,
    input  logic [31:0] input_mem_acess_addr,
    input  logic [31:0] input_mem_write_data,
    input  logic        input_exr_valid,
    input  logic [5:0]  input_exr_type,
    input  logic [31:0] input_exr_a0,
    output logic        stall_req,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic [31:0] data_rdata,
    input  logic        data_data_ok,
    output logic [31:0] output_write_data,
    output logic        output_exr_valid,
    output logic [5:0]  output_exr_type,
    output logic [31:0] output_exr_a0
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_result;

    logic [5:0]  w_op;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_signed;
    logic [1:0]  w_size;
    logic        w_misaligned;
    logic        w_go;
    logic        w_req;
    logic        w_stall;
    logic        w_complete;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_wdata;
    logic        w_unused;

    assign w_op     = input_inst[31:26];
    assign w_unused = &{1'b0, stall[3:0], input_inst[25:0]};

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = 2'd0;
        case (w_op)
            6'h20: begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd0; end
            6'h21: begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
            6'h23: begin w_is_load  = 1'b1; w_size = 2'd2; end
            6'h24: begin w_is_load  = 1'b1; w_size = 2'd0; end
            6'h25: begin w_is_load  = 1'b1; w_size = 2'd1; end
            6'h28: begin w_is_store = 1'b1; w_size = 2'd0; end
            6'h29: begin w_is_store = 1'b1; w_size = 2'd1; end
            6'h2B: begin w_is_store = 1'b1; w_size = 2'd2; end
            default: ;
        endcase
    end

    assign w_misaligned = (w_is_load | w_is_store) &
                          (((w_size == 2'd1) & input_mem_acess_addr[0]) |
                           ((w_size == 2'd2) & (input_mem_acess_addr[1:0] != 2'b00)));
    assign w_go = (w_is_load | w_is_store) & ~w_misaligned & ~input_exr_valid;

    // Little-endian lane pick from the read word, then sign/zero extension
    assign w_byte = data_rdata[{input_mem_acess_addr[1:0], 3'b000} +: 8];
    assign w_half = input_mem_acess_addr[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        w_load_val = data_rdata;
        if (w_size == 2'd0)
            w_load_val = {{24{w_signed & w_byte[7]}}, w_byte};
        else if (w_size == 2'd1)
            w_load_val = {{16{w_signed & w_half[15]}}, w_half};
    end

    always_comb begin
        w_wdata = input_mem_write_data;
        if (w_size == 2'd0)
            w_wdata = {4{input_mem_write_data[7:0]}};
        else if (w_size == 2'd1)
            w_wdata = {2{input_mem_write_data[15:0]}};
    end

    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE, S_REQ: begin
                if (w_go || r_state == S_REQ) begin
                    w_req = 1'b1;
                    if (data_addr_ok && data_data_ok)
                        w_complete = 1'b1;
                    else if (data_addr_ok)
                        w_next = S_WAIT;
                    else
                        w_next = S_REQ;
                end
            end
            S_WAIT: w_complete = data_data_ok;
            S_DONE: if (!stall[4]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_complete)
            w_next = stall[4] ? S_DONE : S_IDLE;
        w_stall = (w_req | (r_state == S_WAIT)) & ~w_complete;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_complete && w_is_load)
                r_result <= w_load_val;
        end
    end

    // Everything is forced quiet while reset is high so the bus never sees a stray request
    always_comb begin
        stall_req         = 1'b0;
        data_req          = 1'b0;
        data_wr           = 1'b0;
        data_size         = 2'd0;
        data_addr         = 32'd0;
        data_wdata        = 32'd0;
        output_write_data = 32'd0;
        output_exr_valid  = 1'b0;
        output_exr_type   = 6'd0;
        output_exr_a0     = 32'd0;
        if (!reset) begin
            stall_req = w_stall;
            data_req  = w_req;
            if (w_req) begin
                data_wr    = w_is_store;
                data_size  = w_size;
                data_addr  = input_mem_acess_addr;
                data_wdata = w_wdata;
            end
            if (w_is_load)
                output_write_data = w_complete ? w_load_val : r_result;
            else
                output_write_data = input_write_data;
            if (input_exr_valid) begin
                output_exr_valid = 1'b1;
                output_exr_type  = input_exr_type;
                output_exr_a0    = input_exr_a0;
            end else if (w_misaligned) begin
                output_exr_valid = 1'b1;
                output_exr_type  = w_is_store ? EXC_ADES : EXC_ADEL;
                output_exr_a0    = input_mem_acess_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
// Directed spec scenarios plus randomized ops against an arithmetic reference model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  stall;
    logic [31:0] input_inst, input_write_data, input_mem_acess_addr, input_mem_write_data;
    logic        input_exr_valid;
    logic [5:0]  input_exr_type;
    logic [31:0] input_exr_a0;
    logic        stall_req, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] output_write_data;
    logic        output_exr_valid;
    logic [5:0]  output_exr_type;
    logic [31:0] output_exr_a0;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .input_inst(input_inst),
        .input_write_data(input_write_data), .input_mem_acess_addr(input_mem_acess_addr),
        .input_mem_write_data(input_mem_write_data), .input_exr_valid(input_exr_valid),
        .input_exr_type(input_exr_type), .input_exr_a0(input_exr_a0),
        .stall_req(stall_req), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok),
        .output_write_data(output_write_data), .output_exr_valid(output_exr_valid),
        .output_exr_type(output_exr_type), .output_exr_a0(output_exr_a0)
    );

    function automatic bit m_is_load(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction

    function automatic bit m_is_store(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    function automatic logic [1:0] m_size(input logic [5:0] op);
        if (op == 6'h23 || op == 6'h2B) return 2'd2;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (int'(addr[1:0]) * 8)) & 32'hFF;
        h = (rd >> ((int'(addr[1:0]) / 2) * 16)) & 32'hFFFF;
        case (op)
            6'h20:   return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
            6'h21:   return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            6'h24:   return b;
            6'h25:   return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rt);
        if (m_size(op) == 2'd0) return (rt & 32'hFF) * 32'h0101_0101;
        if (m_size(op) == 2'd1) return (rt & 32'hFFFF) * 32'h0001_0001;
        return rt;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        input_inst = 32'd0; input_write_data = 32'd0; input_mem_acess_addr = 32'd0;
        input_mem_write_data = 32'd0; input_exr_valid = 1'b0; input_exr_type = 6'd0;
        input_exr_a0 = 32'd0; stall = 5'd0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'd0;
    endtask

    // Memory op: addr_ok at cycle a, data_ok d cycles later, then h cycles held in MEM/WB
    task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rd, input int a, input int d, input int h);
        logic [31:0] exp;
        logic [31:0] wd;
        wd  = $urandom;
        exp = m_is_load(op) ? m_load(op, addr, rd) : wd;
        input_inst = {op, 26'($urandom)};
        input_mem_acess_addr = addr;
        input_mem_write_data = rt;
        input_write_data = wd;
        input_exr_valid = 1'b0;
        for (int k = 0; k <= a + d; k++) begin
            data_addr_ok = (k == a);
            data_data_ok = (k == a + d);
            data_rdata   = (k == a + d) ? rd : $urandom;
            stall = (k == a + d && h > 0) ? 5'b10000 : 5'($urandom_range(0, 15));
            @(negedge clock);
            checks++;
            if (data_req !== (k <= a)) begin
                failures++;
                $display("FAIL req op=%h k=%0d got=%b exp=%b", op, k, data_req, k <= a);
            end
            checks++;
            if (stall_req !== (k < a + d)) begin
                failures++;
                $display("FAIL stall_req op=%h k=%0d got=%b exp=%b", op, k, stall_req, k < a + d);
            end
            if (data_req) begin
                checks++;
                if ({data_wr, data_size, data_addr, data_wdata} !==
                    {m_is_store(op), m_size(op), addr, m_wdata(op, rt)}) begin
                    failures++;
                    $display("FAIL bus op=%h got wr=%b sz=%0d a=%h wd=%h exp wr=%b sz=%0d a=%h wd=%h",
                             op, data_wr, data_size, data_addr, data_wdata,
                             m_is_store(op), m_size(op), addr, m_wdata(op, rt));
                end
            end
            if (k == a + d) begin
                checks++;
                if (output_write_data !== exp) begin
                    failures++;
                    $display("FAIL result op=%h addr=%h got=%h exp=%h", op, addr, output_write_data, exp);
                end
            end
            step();
        end
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        for (int j = 0; j < h; j++) begin
            stall = (j < h - 1) ? 5'b10000 : 5'b00000;
            @(negedge clock);
            checks++;
            if (data_req !== 1'b0 || stall_req !== 1'b0) begin
                failures++;
                $display("FAIL held_quiet j=%0d got req=%b stall=%b exp 0/0", j, data_req, stall_req);
            end
            checks++;
            if (output_write_data !== exp) begin
                failures++;
                $display("FAIL held_value j=%0d got=%h exp=%h", j, output_write_data, exp);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        input_inst = {6'h23, 26'd0}; input_mem_acess_addr = 32'h100; input_write_data = $urandom;
        input_mem_write_data = $urandom; input_exr_valid = 1'b1; input_exr_type = 6'h3F;
        input_exr_a0 = $urandom; stall = 5'h1F; data_addr_ok = 1'b1; data_data_ok = 1'b1;
        data_rdata = $urandom;
        step(); step();
        @(negedge clock);
        checks++;
        if ({stall_req, data_req, data_wr, data_size, data_addr, data_wdata, output_write_data,
             output_exr_valid, output_exr_type, output_exr_a0} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b stall=%b out=%h exr=%b exp all 0",
                     data_req, stall_req, output_write_data, output_exr_valid);
        end
        step();
        idle_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_misaligned(input logic [5:0] op, input logic [31:0] addr);
        logic [5:0] exp_type;
        exp_type = m_is_store(op) ? 6'h05 : 6'h04;
        input_inst = {op, 26'd0};
        input_mem_acess_addr = addr;
        data_addr_ok = 1'b1;
        @(negedge clock);
        checks++;
        if (data_req !== 1'b0 || stall_req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_quiet op=%h got req=%b stall=%b exp 0/0", op, data_req, stall_req);
        end
        checks++;
        if ({output_exr_valid, output_exr_type, output_exr_a0} !== {1'b1, exp_type, addr}) begin
            failures++;
            $display("FAIL misalign_exr op=%h got v=%b t=%h a0=%h exp v=1 t=%h a0=%h",
                     op, output_exr_valid, output_exr_type, output_exr_a0, exp_type, addr);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_upstream_exc();
        logic [5:0]  t;
        logic [31:0] a0;
        t = 6'($urandom); a0 = $urandom;
        input_inst = {6'h2B, 26'd0};
        input_mem_acess_addr = 32'h103;
        input_exr_valid = 1'b1; input_exr_type = t; input_exr_a0 = a0;
        @(negedge clock);
        checks++;
        if (data_req !== 1'b0 || stall_req !== 1'b0 ||
            {output_exr_valid, output_exr_type, output_exr_a0} !== {1'b1, t, a0}) begin
            failures++;
            $display("FAIL upstream_exc got req=%b v=%b t=%h a0=%h exp req=0 v=1 t=%h a0=%h",
                     data_req, output_exr_valid, output_exr_type, output_exr_a0, t, a0);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_non_mem();
        logic [5:0]  ops [5];
        logic [31:0] wd;
        ops = '{6'h00, 6'h08, 6'h0F, 6'h22, 6'h2A};
        for (int i = 0; i < 5; i++) begin
            wd = $urandom;
            input_inst = {ops[i], 26'($urandom)};
            input_write_data = wd;
            input_mem_acess_addr = $urandom;
            @(negedge clock);
            checks++;
            if (data_req !== 1'b0 || stall_req !== 1'b0 || output_exr_valid !== 1'b0 ||
                output_write_data !== wd) begin
                failures++;
                $display("FAIL non_mem op=%h got req=%b stall=%b exr=%b out=%h exp 0/0/0/%h",
                         ops[i], data_req, stall_req, output_exr_valid, output_write_data, wd);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        input_inst = {6'h23, 26'd0};
        input_mem_acess_addr = 32'h200;
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({stall_req, data_req, output_write_data, output_exr_valid} !== '0) begin
            failures++;
            $display("FAIL reset_mid_quiet got req=%b stall=%b out=%h exp 0", data_req, stall_req,
                     output_write_data);
        end
        step();
        input_inst = {6'h23, 26'd0};
        input_mem_acess_addr = 32'h300;
        data_data_ok = 1'b1;
        @(negedge clock);
        checks++;
        if (data_req !== 1'b1 || stall_req !== 1'b1 || output_write_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_idle got req=%b stall=%b out=%h exp 1/1/0", data_req, stall_req,
                     output_write_data);
        end
        step();
        data_addr_ok = 1'b1;
        data_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        checks++;
        if (stall_req !== 1'b0 || output_write_data !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL reset_mid_after got stall=%b out=%h exp 0/0badf00d", stall_req,
                     output_write_data);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [5:0]  ops [8];
        logic [5:0]  op;
        logic [31:0] addr;
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            addr = $urandom;
            if (m_size(op) == 2'd1) addr[0] = 1'b0;
            if (m_size(op) == 2'd2) addr[1:0] = 2'b00;
            run_op(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        run_op(6'h23, 32'h100, 32'd0, 32'hDEAD_BEEF, 1, 2, 0);
        run_op(6'h20, 32'h103, 32'd0, 32'h80FF_FF00, 0, 1, 0);
        run_op(6'h24, 32'h103, 32'd0, 32'h80FF_FF00, 0, 1, 0);
        run_op(6'h25, 32'h102, 32'd0, 32'h80FF_FF00, 1, 1, 0);
        run_op(6'h29, 32'h102, 32'h1234_ABCD, 32'd0, 1, 2, 0);
        test_misaligned(6'h23, 32'h101);
        test_misaligned(6'h2B, 32'h102);
        test_misaligned(6'h21, 32'h103);
        test_upstream_exc();
        run_op(6'h23, 32'h180, 32'd0, 32'h1357_9BDF, 0, 0, 2);
        test_non_mem();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
